// File: rtl/cse_expr_pipe.sv
// Three-stage valid/ready pipeline computing six results that share the common
// terms A+B, C*D and E-F; full-throughput backpressure and synchronous flush.
module cse_expr_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] F,
    input  logic [WIDTH-1:0] G,
    input  logic [WIDTH-1:0] H,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result1,
    output logic [WIDTH-1:0] result2,
    output logic [WIDTH-1:0] result3,
    output logic [WIDTH-1:0] result4,
    output logic [WIDTH-1:0] result5,
    output logic [WIDTH-1:0] result6,
    output logic             busy
);
    localparam int STAGES = 3;

    typedef logic [WIDTH-1:0] word_t;
    typedef struct packed { word_t ab, cd, ef, b, c, e, f, g, h; } s1_t;
    typedef struct packed { word_t r1, r2, r3, t4, r5, t6, ab, ef; } s2_t;
    typedef struct packed { word_t r1, r2, r3, r4, r5, r6; } s3_t;

    logic [STAGES:1] v_q;
    logic [STAGES:0] vld_pipe;   // bit 0 is this cycle's input transfer
    logic            rdy1, rdy2, rdy3, in_xfer;
    s1_t             s1_d, s1_q;
    s2_t             s2_d, s2_q;
    s3_t             s3_d, s3_q;

    // A stage may load when it is empty or its occupant moves on this cycle.
    assign rdy3     = !v_q[3] | out_ready;
    assign rdy2     = !v_q[2] | rdy3;
    assign rdy1     = !v_q[1] | rdy2;
    assign in_ready = rdy1 & !flush;
    assign in_xfer  = in_valid & in_ready;
    assign vld_pipe = {v_q, in_xfer};

    always_comb begin
        s1_d    = '0;
        s1_d.ab = A + B;
        s1_d.cd = C * D;
        s1_d.ef = E - F;
        s1_d.b  = B;
        s1_d.c  = C;
        s1_d.e  = E;
        s1_d.f  = F;
        s1_d.g  = G;
        s1_d.h  = H;
    end

    always_comb begin
        s2_d    = '0;
        s2_d.r1 = s1_q.ab + s1_q.cd;
        s2_d.r2 = s1_q.cd + s1_q.ef;
        s2_d.r3 = s1_q.ab + s1_q.g + s1_q.h;
        s2_d.t4 = s1_q.cd + s1_q.e;
        s2_d.r5 = s1_q.cd + s1_q.b - (s1_q.f + s1_q.ab);
        s2_d.t6 = s1_q.ab + s1_q.c;
        s2_d.ab = s1_q.ab;
        s2_d.ef = s1_q.ef;
    end

    always_comb begin
        s3_d    = '0;
        s3_d.r1 = s2_q.r1;
        s3_d.r2 = s2_q.r2;
        s3_d.r3 = s2_q.r3;
        s3_d.r4 = s2_q.t4 * s2_q.ab;
        s3_d.r5 = s2_q.r5;
        s3_d.r6 = s2_q.t6 * s2_q.ef;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else if (flush) begin
            v_q <= '0;
        end else begin
            if (rdy1) v_q[1] <= vld_pipe[0];
            if (rdy2) v_q[2] <= vld_pipe[1];
            if (rdy3) v_q[3] <= vld_pipe[2];
        end
    end

    // Data registers only move with a valid occupant, so stalled results hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            if (rdy1 && vld_pipe[0]) s1_q <= s1_d;
            if (rdy2 && vld_pipe[1]) s2_q <= s2_d;
            if (rdy3 && vld_pipe[2]) s3_q <= s3_d;
        end
    end

    assign out_valid = v_q[3];
    assign busy      = |v_q;
    assign result1   = s3_q.r1;
    assign result2   = s3_q.r2;
    assign result3   = s3_q.r3;
    assign result4   = s3_q.r4;
    assign result5   = s3_q.r5;
    assign result6   = s3_q.r6;

endmodule
